// File: rtl/sm4_mode_ctrl.sv
// Block-cipher mode controller (ECB/CBC/CTR) sitting between a host block stream and one SM4 core.
// Latency: input accept -> core request 1 cycle, core result -> data_v_o 1 cycle; one block in flight.
// Backpressure: data_yumi_i low holds OUT; no input is accepted and no core request is made until consumed.
//
// Ports:
//   clk_i, reset_n_i          clock (rising edge), asynchronous active-low reset
//   start_i, mode_i,          message start (IDLE only) with mode, direction, key and IV/counter,
//   decrypt_i, key_i, iv_i    all latched on start
//   data_*_i / data_ready_o   host input block stream (valid/ready)
//   data_*_o / data_yumi_i    host output block stream (valid/yumi)
//   core_*                    SM4 core request (valid/ready) and response (valid/yumi)
//   busy_o, state_o,          status: not idle, raw state encoding, blocks delivered in the
//   blocks_done_o             current message (held in IDLE until the next start)
`timescale 1ns/1ps

module sm4_mode_ctrl #(
    parameter int group_size_p = 128,
    parameter int ctr_width_p  = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    start_i,
    input  logic [1:0]              mode_i,
    input  logic                    decrypt_i,
    input  logic [group_size_p-1:0] key_i,
    input  logic [group_size_p-1:0] iv_i,

    input  logic [group_size_p-1:0] data_i,
    input  logic                    data_last_i,
    input  logic                    data_v_i,
    output logic                    data_ready_o,

    output logic [group_size_p-1:0] data_o,
    output logic                    data_last_o,
    output logic                    data_v_o,
    input  logic                    data_yumi_i,

    output logic [group_size_p-1:0] core_content_o,
    output logic [group_size_p-1:0] core_key_o,
    output logic                    core_decode_o,
    output logic                    core_v_o,
    input  logic                    core_ready_i,
    input  logic [group_size_p-1:0] core_crypt_i,
    input  logic                    core_v_i,
    output logic                    core_yumi_o,

    output logic                    busy_o,
    output logic [2:0]              state_o,
    output logic [ctr_width_p-1:0]  blocks_done_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IN   = 3'd1,
        ISSUE     = 3'd2,
        WAIT_CORE = 3'd3,
        OUT       = 3'd4
    } state_e;

    localparam logic [1:0] MODE_ECB  = 2'd0;
    localparam logic [1:0] MODE_CBC  = 2'd1;
    localparam logic [1:0] MODE_CTR  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    // Selects the counter field of the IV; bits above it are carried through untouched.
    localparam logic [group_size_p-1:0] CTR_MASK =
        {group_size_p{1'b1}} >> (group_size_p - ctr_width_p);
    localparam logic [group_size_p-1:0] GRP_ONE = group_size_p'(1);
    localparam logic [ctr_width_p-1:0]  CNT_ONE = ctr_width_p'(1);

    state_e state_q, state_d;

    logic [1:0]              mode_q, mode_d;
    logic                    decrypt_q, decrypt_d;
    logic [group_size_p-1:0] key_q, key_d;
    logic [group_size_p-1:0] chain_q, chain_d;
    logic [group_size_p-1:0] data_q, data_d;
    logic                    last_q, last_d;
    logic [group_size_p-1:0] content_q, content_d;
    logic                    decode_q, decode_d;
    logic [group_size_p-1:0] out_q, out_d;
    logic [ctr_width_p-1:0]  blocks_done_q, blocks_done_d;

    logic [group_size_p-1:0] ctr_next;

    // Full-width add, then keep only the counter field: the carry out of the
    // counter field is dropped so the upper IV bits never change.
    assign ctr_next = (chain_q & ~CTR_MASK) | ((chain_q + GRP_ONE) & CTR_MASK);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        data_ready_o = 1'b0;
        data_v_o     = 1'b0;
        data_last_o  = 1'b0;
        core_v_o     = 1'b0;
        core_yumi_o  = 1'b0;
        busy_o       = 1'b1;

        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = WAIT_IN;
                end
            end
            WAIT_IN: begin
                data_ready_o = 1'b1;
                if (data_v_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                core_v_o = 1'b1;
                if (core_ready_i) begin
                    state_d = WAIT_CORE;
                end
            end
            WAIT_CORE: begin
                // Response is captured and acknowledged in the same cycle.
                core_yumi_o = core_v_i;
                if (core_v_i) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                data_v_o    = 1'b1;
                data_last_o = last_q;
                if (data_yumi_i) begin
                    state_d = last_q ? IDLE : WAIT_IN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state: latching, pre-core XOR, post-core XOR, chaining
    // ------------------------------------------------------------------
    always_comb begin
        mode_d        = mode_q;
        decrypt_d     = decrypt_q;
        key_d         = key_q;
        chain_d       = chain_q;
        data_d        = data_q;
        last_d        = last_q;
        content_d     = content_q;
        decode_d      = decode_q;
        out_d         = out_q;
        blocks_done_d = blocks_done_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    // The reserved mode is folded into ECB here so that the
                    // rest of the datapath only ever sees three modes.
                    mode_d        = (mode_i == MODE_RSVD) ? MODE_ECB : mode_i;
                    decrypt_d     = decrypt_i;
                    key_d         = key_i;
                    chain_d       = iv_i;
                    blocks_done_d = '0;
                end
            end
            WAIT_IN: begin
                if (data_v_i) begin
                    data_d = data_i;
                    last_d = data_last_i;
                    case (mode_q)
                        MODE_CBC: begin
                            content_d = decrypt_q ? data_i : (data_i ^ chain_q);
                            decode_d  = decrypt_q;
                        end
                        MODE_CTR: begin
                            // CTR only ever runs the core forward; the
                            // keystream is XORed with the data afterwards.
                            content_d = chain_q;
                            decode_d  = 1'b0;
                        end
                        default: begin
                            content_d = data_i;
                            decode_d  = decrypt_q;
                        end
                    endcase
                end
            end
            WAIT_CORE: begin
                if (core_v_i) begin
                    case (mode_q)
                        MODE_CBC: begin
                            if (decrypt_q) begin
                                out_d   = core_crypt_i ^ chain_q;
                                chain_d = data_q;
                            end else begin
                                out_d   = core_crypt_i;
                                chain_d = core_crypt_i;
                            end
                        end
                        MODE_CTR: begin
                            out_d   = core_crypt_i ^ data_q;
                            chain_d = ctr_next;
                        end
                        default: begin
                            out_d = core_crypt_i;
                        end
                    endcase
                end
            end
            OUT: begin
                if (data_yumi_i) begin
                    blocks_done_d = blocks_done_q + CNT_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mode_q        <= MODE_ECB;
            decrypt_q     <= 1'b0;
            key_q         <= '0;
            chain_q       <= '0;
            data_q        <= '0;
            last_q        <= 1'b0;
            content_q     <= '0;
            decode_q      <= 1'b0;
            out_q         <= '0;
            blocks_done_q <= '0;
        end else begin
            mode_q        <= mode_d;
            decrypt_q     <= decrypt_d;
            key_q         <= key_d;
            chain_q       <= chain_d;
            data_q        <= data_d;
            last_q        <= last_d;
            content_q     <= content_d;
            decode_q      <= decode_d;
            out_q         <= out_d;
            blocks_done_q <= blocks_done_d;
        end
    end

    // Core request fields and the output block come straight from registers,
    // so they stay stable for as long as the corresponding handshake stalls.
    assign data_o         = out_q;
    assign core_content_o = content_q;
    assign core_decode_o  = decode_q;
    assign core_key_o     = key_q;
    assign state_o        = state_q;
    assign blocks_done_o  = blocks_done_q;

endmodule

// File: doc/sm4_mode_ctrl.md
Name: sm4_mode_ctrl

Overview:
Block-cipher mode controller between the host stream interface and a single SM4 encryptor core. It sequences multi-block messages in ECB, CBC or CTR mode and owns the chaining/IV register. It also performs the pre- and post-core XORs and handles counter increment and per-block handshakes on both sides. One block is in flight at a time; the core's own round-key cache is reused because the key is constant for a whole message.

Parameters:
group_size_p, 128, SM4 block and key width in bits (fixed by SM4; parametrised for reuse).
ctr_width_p, 32, number of low counter bits incremented in CTR mode (1..group_size_p).

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous, active-low reset
start_i  in  1  message start; sampled only in IDLE
mode_i  in  2  0=ECB, 1=CBC, 2=CTR, 3=reserved (treated as ECB); latched on start
decrypt_i  in  1  1=decrypt; latched on start
key_i  in  group_size_p  message key; latched on start
iv_i  in  group_size_p  IV/initial counter; latched on start
data_i  in  group_size_p  input block
data_last_i  in  1  marks final block of message
data_v_i  in  1  input valid
data_ready_o  out  1  input ready
data_o  out  group_size_p  output block
data_last_o  out  1  final output block
data_v_o  out  1  output valid
data_yumi_i  in  1  output consumed (asserted only when data_v_o=1)
core_content_o  out  group_size_p  to core content_i
core_key_o  out  group_size_p  to core key_i
core_decode_o  out  1  to core encode_or_decode_i (1=decode)
core_v_o  out  1  to core v_i
core_ready_i  in  1  from core ready_o
core_crypt_i  in  group_size_p  from core crypt_o
core_v_i  in  1  from core v_o
core_yumi_o  out  1  to core yumi_i
busy_o  out  1  state != IDLE
state_o  out  3  current state encoding
blocks_done_o  out  ctr_width_p  blocks delivered in current message

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs and registers are 0, including chain_r, key_r, data_r and blocks_done_o.
- States: IDLE=0, WAIT_IN=1, ISSUE=2, WAIT_CORE=3, OUT=4.
- IDLE: data_ready_o=0, core_v_o=0. On start_i, latch mode/decrypt/key/iv, set chain_r=iv_i, clear blocks_done_o, go to WAIT_IN.
- start_i is ignored in every state except IDLE.
- WAIT_IN: data_ready_o=1. On data_v_i&data_ready_o, register data_r=data_i, last_r=data_last_i and the core input, then go to ISSUE.
- Core input by mode:
  - ECB: content=data, decode=decrypt_r.
  - CBC encrypt: content=data^chain_r, decode=0.
  - CBC decrypt: content=data, decode=1.
  - CTR: content=chain_r, decode=0 for both directions.
- ISSUE: core_v_o=1, with core_content_o, core_decode_o and core_key_o=key_r held stable. On core_ready_i, go to WAIT_CORE.
- core_key_o equals key_r in every non-IDLE state.
- WAIT_CORE: core_yumi_o=core_v_i (consume in the same cycle). On core_v_i, register the output and go to OUT.
- Output and chain update by mode:
  - ECB: out=crypt.
  - CBC encrypt: out=crypt, chain_r<=crypt.
  - CBC decrypt: out=crypt^chain_r, chain_r<=data_r.
  - CTR: out=crypt^data_r, chain_r[ctr_width_p-1:0]<=+1.
- CTR counter wrap: the low ctr_width_p bits wrap modulo 2^ctr_width_p; upper bits are never modified.
- OUT: data_v_o=1, data_last_o=last_r. data_o is stable until consumed. On data_yumi_i, blocks_done_o++ (wraps), then go to IDLE if last_r, else WAIT_IN.
- Backpressure: no new input is accepted and no core request is made while in OUT. Throughput is at most one block per (core latency + 3) cycles.
- Core signals (core_v_i, core_crypt_i) arriving outside WAIT_CORE are ignored and never acknowledged.
- blocks_done_o holds its final value in IDLE until the next start_i.

Test Plan:
1. ECB encrypt: key=data=0123456789abcdeffedcba9876543210, last=1 -> data_o=681edf34d206965e86b3e94f536e4246, data_last_o=1, returns to IDLE, blocks_done_o=1.
2. CBC encrypt, iv=0, two blocks P1=P2=the test vector -> block 1 out=681edf34d206965e86b3e94f536e4246; block 2 core_content_o=P2^C1.
3. CBC decrypt of the case-2 ciphertexts with the same iv -> outputs equal P1 and P2, and chain_r equals C1 before block 2.
4. CTR, iv low word=ffffffff, upper bits=A5A5... -> second core_content_o low word=00000000 with upper 96 bits unchanged. Decrypting the output with the same iv restores the plaintext.
5. Backpressure: hold data_yumi_i=0 for 10 cycles in OUT -> data_o/data_v_o stable, data_ready_o=0, core_v_o=0. start_i pulsed meanwhile has no effect.
6. Assert reset_n_i=0 mid WAIT_CORE -> all outputs 0 in the same cycle. After release, state=IDLE and a new ECB message reproduces the scenario-1 result.
